fifo_stream_reader: RTL and testbench

- Read-side companion to the team's synchronous FIFO.
- Drains the FIFO pop port (rd_en / empty / registered data_out with 1-cycle read latency) and presents the words as a valid/ready stream.
- Holds words in a small internal buffer so the stream runs at one word per cycle under continuous ready, with no word lost or duplicated under backpressure.
- Sits between the FIFO instance and any valid/ready consumer.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_stream_buf.sv | 67 ++++++
 rtl/fifo_stream_reader.sv | 70 +++++++
 tb/tb_fifo_stream_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO and its stream-side companions.
// Imported by the reader and its buffer.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
  } stream_t;

endpackage

// File: rtl/fifo_stream_buf.sv
// Small register-file buffer between the FIFO read port and the stream.
// Write on in-flight capture, read on stream transfer.
module fifo_stream_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_en_i,
  output logic [cnt_w(BUF_DEPTH)-1:0]   occ_o,
  output logic [DATA_WIDTH-1:0]         head_o
);

  localparam int OW = cnt_w(BUF_DEPTH);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [OW-1:0]         occ_q, occ_d;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Next pointers and occupancy; wrap at BUF_DEPTH.
  always_comb begin
    wptr_d = wr_en_i ? nxt(wptr_q) : wptr_q;
    rptr_d = rd_en_i ? nxt(rptr_q) : rptr_q;
    occ_d  = occ_q;
    unique case (1'b1)
      wr_en_i && !rd_en_i: occ_d = occ_q + 1'b1;
      rd_en_i && !wr_en_i: occ_d = occ_q - 1'b1;
      default:             occ_d = occ_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wptr_q] <= wr_data_i;
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO pop port into a valid/ready stream.
// Issue logic, in-flight tracking and the transfer counter.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_rd_en,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [cnt_w(BUF_DEPTH)-1:0] level,
  output logic [CNT_WIDTH-1:0]        delivered
);

  localparam int OW = cnt_w(BUF_DEPTH);

  logic                 inflight_q;
  logic [CNT_WIDTH-1:0] dlv_q, dlv_d;
  logic [OW-1:0]        occ;
  logic [OW:0]          demand;
  logic                 pop;

  // Issue a pop only when the word is sure to have a slot on arrival.
  always_comb begin
    pop    = m_valid && m_ready;
    demand = {1'b0, occ}
           + (OW+1)'(inflight_q)
           - (OW+1)'(pop);
    fifo_rd_en = reset_n
              && !fifo_empty
              && (demand < (OW+1)'(BUF_DEPTH));
    dlv_d  = pop ? dlv_q + 1'b1 : dlv_q;
  end

  // In-flight flag tracks last cycle's pop; counter wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      dlv_q      <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      dlv_q      <= dlv_d;
    end
  end

  fifo_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (inflight_q),
    .wr_data_i (fifo_data),
    .rd_en_i   (pop),
    .occ_o     (occ),
    .head_o    (m_data)
  );

  assign m_valid   = (occ != '0);
  assign level     = occ + OW'(inflight_q);
  assign delivered = dlv_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO.
// A second instance with a 4-bit counter covers wrap-around.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [1:0]  level;
  logic [15:0] delivered;

  logic        rd_en_w;
  logic        m_valid_w;
  logic [7:0]  m_data_w;
  logic [1:0]  level_w;
  logic [3:0]  delivered_w;

  int checks = 0;
  int errors = 0;

  logic [7:0] fmem [0:1023];
  int n_push  = 0;
  int n_pop   = 0;
  int exp_idx = 0;
  int n_obs   = 0;
  int rd_viol = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (n_push == n_pop);

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (2),
    .CNT_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level),
    .delivered  (delivered)
  );

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (2),
    .CNT_WIDTH  (4)
  ) u_w (
    .clk        (clk),
    .reset_n    (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (rd_en_w),
    .m_valid    (m_valid_w),
    .m_ready    (m_ready),
    .m_data     (m_data_w),
    .level      (level_w),
    .delivered  (delivered_w)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[n_push] = d;
    n_push++;
  endtask

  // Behavioural FIFO: registered read data, one-cycle latency.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (n_pop == n_push) begin
        rd_viol++;
      end else begin
        fifo_data <= fmem[n_pop];
        n_pop     <= n_pop + 1;
      end
    end
  end

  // Scoreboard: every transfer must carry the next popped word.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = n_pop;
    end else if (m_valid && m_ready) begin
      chk("stream_order", m_data, fmem[exp_idx]);
      exp_idx++;
      n_obs++;
    end
  end

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (!(exp_idx == n_push && n_pop == n_push
             && !m_valid) && c < maxc) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_done", c < maxc, 1);
  endtask

  typedef struct {
    int         npush;
    logic [7:0] base;
    logic       rdy;
    logic       rd;
    logic       vld;
    logic [7:0] data;
    int         lvl;
    int         del;
  } vec_t;

  vec_t tv [19];

  initial begin
    int cnt;
    int nrand;
    int obs0;

    tv[0]  = '{1, 8'hA5, 1, 1, 0, 8'h00, 0, 0};
    tv[1]  = '{0, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    tv[2]  = '{0, 8'h00, 1, 0, 1, 8'hA5, 1, 0};
    tv[3]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 1};
    tv[4]  = '{4, 8'h01, 0, 1, 0, 8'h00, 0, 1};
    tv[5]  = '{0, 8'h00, 0, 1, 0, 8'h00, 1, 1};
    for (int i = 6; i < 14; i++) begin
      tv[i] = '{0, 8'h00, 0, 0, 1, 8'h01, 2, 1};
    end
    tv[14] = '{0, 8'h00, 1, 1, 1, 8'h01, 2, 1};
    tv[15] = '{0, 8'h00, 1, 1, 1, 8'h02, 2, 2};
    tv[16] = '{0, 8'h00, 1, 0, 1, 8'h03, 2, 3};
    tv[17] = '{0, 8'h00, 1, 0, 1, 8'h04, 1, 4};
    tv[18] = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 5};

    rst_n   = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_delivered", delivered, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      for (int k = 0; k < tv[i].npush; k++) begin
        push(tv[i].base + 8'(k));
      end
      m_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i),
          fifo_rd_en, tv[i].rd);
      chk($sformatf("v%0d_valid", i),
          m_valid, tv[i].vld);
      chk($sformatf("v%0d_level", i),
          level, tv[i].lvl);
      chk($sformatf("v%0d_delivered", i),
          delivered, tv[i].del);
      if (tv[i].vld) begin
        chk($sformatf("v%0d_data", i),
            m_data, tv[i].data);
      end
      @(posedge clk); #1;
    end

    for (int k = 1; k <= 8; k++) push(8'(k));
    m_ready = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!m_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("stream_latency", cnt, 2);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("stream_valid%0d", k), m_valid, 1);
      chk($sformatf("stream_data%0d", k), m_data, k);
      @(negedge clk);
    end
    chk("stream_end_valid", m_valid, 0);
    chk("stream_delivered", delivered, 13);
    @(posedge clk); #1;

    nrand = 0;
    obs0  = n_obs;
    for (int c = 0; c < 2000 && nrand < 200; c++) begin
      if (($urandom % 2) == 1) begin
        push(8'($urandom_range(0, 255)));
        nrand++;
      end
      m_ready = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    drain(100);
    chk("rand_count", n_obs - obs0, 200);
    chk("rand_delivered", delivered, 213);
    chk("rand_delivered_w4", delivered_w, 5);
    chk("rd_en_while_empty", rd_viol, 0);

    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(8'h91 + 8'(k));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_level", level, 2);
    chk("mid_valid", m_valid, 1);
    chk("mid_data", m_data, 8'h91);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_delivered", delivered, 0);
    chk("arst_data", m_data, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_fifo_nonempty", fifo_empty, 0);
      chk("arst_rd_en_held", fifo_rd_en, 0);
    end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    drain(50);
    chk("post_rst_delivered", delivered, 2);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) push(8'h40 + 8'(k));
    drain(60);
    chk("wrap_delivered16", delivered, 17);
    chk("wrap_delivered4", delivered_w, 1);
    chk("wrap_level", level, 0);
    chk("wrap_rd_en_viol", rd_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
